unidade_controle_desafio: RTL
=============================

# unidade_controle_desafio

Moore control unit for the memory-challenge game. It sequences the game datapath: address and round counters, play register, memory-bank select, LED display of the sequence, and per-move timeout. Datapath comparator and counter flags come in; the block drives one-cycle control strobes, final-status flags and a debug state code. It sits between the top-level game module and its datapath and owns the only timing counter in the game.

## Interface
- MOSTRA_CICLOS, 500: cycles each sequence element is lit, and also the length of the dark gap after it.
- TIMEOUT_CICLOS, 3000: cycles allowed per move before timeout.
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; low forces the reset state.
- jogar  in  1  level start request.
- nivel  in  1  sampled at start: 1 = 16 rounds, 0 = 8 rounds.
- memoria  in  1  sampled at start: selects the sequence memory bank.
- tem_jogada  in  1  one-cycle pulse from the datapath edge detector when a button is pressed.
- chaves_igual_memoria  in  1  registered play equals memory data.
- endereco_igual_sequencia  in  1  address counter equals round counter.
- meio_s  in  1  round counter = 7.
- fim_s  in  1  round counter = 15.
- zera_e, conta_e, zera_s, conta_s, zera_r, registra_r  out  1 each  datapath counter and register controls.
- mostra_leds  out  1  LEDs show memory data; when 0, LEDs show the registered play.
- seletor_memoria  out  1  latched `memoria`.
- ganhou, perdeu, timeout, pronto  out  1 each  result flags.
- db_estado  out  5  current state code.

## Operation
States and codes:
- INICIAL 00
- PREPARA 01
- INICIO_RODADA 02
- MOSTRA 03
- INTERVALO 04
- PROX_MOSTRA 05
- ZERA_END 06
- ESPERA 07
- REGISTRA 08
- COMPARA 09
- PROX_END 0A
- PROX_RODADA 0C
- FIM_GANHOU 0D
- FIM_PERDEU 0E
- FIM_TIMEOUT 0F

Transitions and outputs:
- INICIAL: jogar=1 -> PREPARA; otherwise stay.
- PREPARA: zera_e=zera_s=zera_r=1. Latch nivel into nivel_l and memoria into seletor_memoria. -> INICIO_RODADA.
- INICIO_RODADA: zera_e=1, timer cleared. -> MOSTRA.
- MOSTRA: mostra_leds=1, timer counts. At timer=MOSTRA_CICLOS-1 -> INTERVALO, timer cleared.
- INTERVALO: timer counts. At MOSTRA_CICLOS-1: endereco_igual_sequencia -> ZERA_END, else -> PROX_MOSTRA.
- PROX_MOSTRA: conta_e=1. -> MOSTRA.
- ZERA_END: zera_e=1, timer cleared. -> ESPERA.
- ESPERA: timer counts.
  - tem_jogada -> REGISTRA.
  - Else at timer=TIMEOUT_CICLOS-1 -> FIM_TIMEOUT.
  - A press in the final timer cycle wins over timeout.
- REGISTRA: registra_r=1. -> COMPARA.
- COMPARA (priority order):
  - !chaves_igual_memoria -> FIM_PERDEU.
  - endereco_igual_sequencia and fim_rod -> FIM_GANHOU.
  - endereco_igual_sequencia -> PROX_RODADA.
  - Otherwise -> PROX_END.
  - fim_rod = nivel_l ? fim_s : meio_s.
- PROX_END: conta_e=1, timer cleared. -> ESPERA.
- PROX_RODADA: conta_s=1. -> INICIO_RODADA.
- FIM_*:
  - pronto=1, and exactly one of ganhou/perdeu/timeout is 1.
  - Held until jogar=1 -> PREPARA.
  - The datapath is not cleared on entry; the last play remains visible.
- All control strobes are 0 in every state not listed as driving them.
- Timer width is ceil(log2(max(MOSTRA_CICLOS, TIMEOUT_CICLOS))). The timer never wraps: it is cleared on every state entry that names it and saturates otherwise.
- nivel and memoria changes after PREPARA have no effect until the next start. seletor_memoria holds its value through the FIM states.

## Timing
- Reset (reset=0, asynchronous) forces state INICIAL, timer 0, nivel_l 0, seletor_memoria 0, and every output 0 (db_estado=00). Release is synchronous to the next clock edge.
- All outputs are decoded from registered state, so they are glitch-free with no combinational path from any input.
- Start latency:
  - jogar sampled high at edge k puts PREPARA outputs valid after edge k, INICIO_RODADA after k+1, MOSTRA after k+2.
  - A one-cycle jogar pulse is sufficient.
  - jogar held high has no further effect until a FIM state is reached.
- Round r (0-based) shows r+1 elements. Show phase lasts (r+1)·2·MOSTRA_CICLOS + r + 2 cycles, counted from INICIO_RODADA entry to ESPERA entry.
- Move latency: tem_jogada at edge k puts REGISTRA after k, COMPARA after k+1, and the next state after k+2. tem_jogada arriving outside ESPERA is ignored.
- A reset pulse mid-game aborts immediately. No result flag is raised.

## Test plan
(Bench parameters: MOSTRA_CICLOS=4, TIMEOUT_CICLOS=20.)
- Reset low for 1 cycle, then idle 10 cycles -> db_estado=00; pronto, ganhou, perdeu, timeout and mostra_leds all 0.
- jogar pulse, nivel=0, memoria=1 -> PREPARA with zera_e, zera_s, zera_r high for 1 cycle; seletor_memoria=1; mostra_leds high for exactly 4 cycles; then ESPERA.
- Model datapath always answering correctly, 8 rounds -> conta_s pulses 7 times; ganhou=1 and pronto=1; db_estado=0D held until jogar.
- Same with nivel=1 -> 15 conta_s pulses before FIM_GANHOU. nivel toggled mid-game -> no change in round count.
- Round 0 with a wrong play (chaves_igual_memoria=0 in COMPARA) -> perdeu=1, db_estado=0E. No press for 20 cycles in ESPERA -> timeout=1, db_estado=0F. tem_jogada exactly on cycle 19 -> REGISTRA, no timeout.
- reset low while in MOSTRA -> asynchronous return to 00 and all outputs 0 before the next edge. jogar from FIM_PERDEU -> PREPARA and flags cleared.

Source files
------------

// File: rtl/unidade_controle_desafio.sv
// Purpose : Moore control unit sequencing the memory-challenge game datapath.
// Latency : outputs registered from next state, valid one cycle after the deciding edge.
// Backpr. : none; input pulses are sampled only in the states that use them.
//
// Ports:
//   clock, reset (async active-low)
//   jogar, nivel, memoria            - start request and per-game options
//   tem_jogada                       - one-cycle button press pulse
//   chaves_igual_memoria,
//   endereco_igual_sequencia,
//   meio_s, fim_s                    - datapath comparator / counter flags
//   zera_e, conta_e, zera_s, conta_s,
//   zera_r, registra_r               - datapath counter/register strobes
//   mostra_leds, seletor_memoria     - display source and memory bank select
//   ganhou, perdeu, timeout, pronto  - result flags
//   db_estado                        - current state code
module unidade_controle_desafio #(
    parameter int MOSTRA_CICLOS  = 500,
    parameter int TIMEOUT_CICLOS = 3000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic       nivel,
    input  logic       memoria,
    input  logic       tem_jogada,
    input  logic       chaves_igual_memoria,
    input  logic       endereco_igual_sequencia,
    input  logic       meio_s,
    input  logic       fim_s,
    output logic       zera_e,
    output logic       conta_e,
    output logic       zera_s,
    output logic       conta_s,
    output logic       zera_r,
    output logic       registra_r,
    output logic       mostra_leds,
    output logic       seletor_memoria,
    output logic       ganhou,
    output logic       perdeu,
    output logic       timeout,
    output logic       pronto,
    output logic [4:0] db_estado
);

    localparam int TMAX = (MOSTRA_CICLOS > TIMEOUT_CICLOS) ? MOSTRA_CICLOS : TIMEOUT_CICLOS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] MOSTRA_FIM  = TW'(MOSTRA_CICLOS - 1);
    localparam logic [TW-1:0] TIMEOUT_FIM = TW'(TIMEOUT_CICLOS - 1);

    typedef enum logic [4:0] {
        INICIAL       = 5'h00,
        PREPARA       = 5'h01,
        INICIO_RODADA = 5'h02,
        MOSTRA        = 5'h03,
        INTERVALO     = 5'h04,
        PROX_MOSTRA   = 5'h05,
        ZERA_END      = 5'h06,
        ESPERA        = 5'h07,
        REGISTRA      = 5'h08,
        COMPARA       = 5'h09,
        PROX_END      = 5'h0A,
        PROX_RODADA   = 5'h0C,
        FIM_GANHOU    = 5'h0D,
        FIM_PERDEU    = 5'h0E,
        FIM_TIMEOUT   = 5'h0F
    } t_estado;

    t_estado         r_estado;
    t_estado         w_prox;
    logic [TW-1:0]   r_timer;
    logic            r_nivel;
    logic            w_fim_rod;

    // Last round depends on the difficulty captured at game start.
    assign w_fim_rod = r_nivel ? fim_s : meio_s;

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            INICIAL:       if (jogar) w_prox = PREPARA;
            PREPARA:       w_prox = INICIO_RODADA;
            INICIO_RODADA: w_prox = MOSTRA;
            MOSTRA:        if (r_timer == MOSTRA_FIM) w_prox = INTERVALO;
            INTERVALO: begin
                if (r_timer == MOSTRA_FIM)
                    w_prox = endereco_igual_sequencia ? ZERA_END : PROX_MOSTRA;
            end
            PROX_MOSTRA:   w_prox = MOSTRA;
            ZERA_END:      w_prox = ESPERA;
            ESPERA: begin
                // A press on the last allowed cycle still counts as a move.
                if (tem_jogada)
                    w_prox = REGISTRA;
                else if (r_timer == TIMEOUT_FIM)
                    w_prox = FIM_TIMEOUT;
            end
            REGISTRA:      w_prox = COMPARA;
            COMPARA: begin
                if (!chaves_igual_memoria)
                    w_prox = FIM_PERDEU;
                else if (endereco_igual_sequencia && w_fim_rod)
                    w_prox = FIM_GANHOU;
                else if (endereco_igual_sequencia)
                    w_prox = PROX_RODADA;
                else
                    w_prox = PROX_END;
            end
            PROX_END:      w_prox = ESPERA;
            PROX_RODADA:   w_prox = INICIO_RODADA;
            FIM_GANHOU,
            FIM_PERDEU,
            FIM_TIMEOUT:   if (jogar) w_prox = PREPARA;
            default:       w_prox = INICIAL;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up
    // with r_estado and never see an input combinationally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado        <= INICIAL;
            r_timer         <= '0;
            r_nivel         <= 1'b0;
            seletor_memoria <= 1'b0;
            zera_e          <= 1'b0;
            conta_e         <= 1'b0;
            zera_s          <= 1'b0;
            conta_s         <= 1'b0;
            zera_r          <= 1'b0;
            registra_r      <= 1'b0;
            mostra_leds     <= 1'b0;
            ganhou          <= 1'b0;
            perdeu          <= 1'b0;
            timeout         <= 1'b0;
            pronto          <= 1'b0;
            db_estado       <= 5'h00;
        end else begin
            r_estado <= w_prox;

            // Every timed state needs a fresh count on entry (including each
            // MOSTRA re-entered from PROX_MOSTRA), so any transition clears it.
            if (w_prox != r_estado)
                r_timer <= '0;
            else if (r_timer != {TW{1'b1}})
                r_timer <= r_timer + 1'b1;

            // Options are captured on the start edge and then ignored.
            if (w_prox == PREPARA) begin
                r_nivel         <= nivel;
                seletor_memoria <= memoria;
            end

            zera_e      <= (w_prox == PREPARA) || (w_prox == INICIO_RODADA) || (w_prox == ZERA_END);
            conta_e     <= (w_prox == PROX_MOSTRA) || (w_prox == PROX_END);
            zera_s      <= (w_prox == PREPARA);
            conta_s     <= (w_prox == PROX_RODADA);
            zera_r      <= (w_prox == PREPARA);
            registra_r  <= (w_prox == REGISTRA);
            mostra_leds <= (w_prox == MOSTRA);
            ganhou      <= (w_prox == FIM_GANHOU);
            perdeu      <= (w_prox == FIM_PERDEU);
            timeout     <= (w_prox == FIM_TIMEOUT);
            pronto      <= (w_prox == FIM_GANHOU) || (w_prox == FIM_PERDEU) || (w_prox == FIM_TIMEOUT);
            db_estado   <= w_prox;
        end
    end

endmodule
